fifo_stream_adapter: RTL and testbench

- Sits directly downstream of the team's synchronous FIFO read port. The FIFO delivers data one cycle after rd_en and updates rd_data only when rd_en && !empty.
- Converts that port into a first-word-fall-through valid/ready stream for downstream consumers.
- Holds a 2-entry output buffer so reads issued before a stall are never lost.
- Sustains 1 beat/cycle when m_ready is held high.

---
 rtl/fifo_stream_adapter.sv | 86 ++++++++
 tb/tb_fifo_stream_adapter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_adapter.sv
// FIFO read-port to first-word-fall-through valid/ready stream adapter with a 2-entry output buffer.
// Optional statistics counters are enabled by defining FIFO_STREAM_ADAPTER_STATS_EN.
module fifo_stream_adapter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    input  logic             flush
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    ,
    output logic [15:0]      beat_cnt,
    output logic [15:0]      stall_cnt
`endif
);

    logic [1:0]       occ;
    logic             pend;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;

    logic             pop;
    logic [1:0]       level;
    logic [1:0]       occ_popped;
    logic [1:0]       occ_next;

    assign pop        = m_valid && m_ready;
    assign level      = occ + {1'b0, pend} - {1'b0, pop};
    assign occ_popped = occ - {1'b0, pop};
    assign occ_next   = occ_popped + {1'b0, pend};

    // m_ready reaches fifo_rd_en combinationally so a pop frees a slot for a same-cycle issue.
    assign fifo_rd_en = !rst && !fifo_empty && !flush && (level < 2'd2);
    assign m_data     = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ     <= '0;
            pend    <= 1'b0;
            m_valid <= 1'b0;
            head    <= '0;
            skid    <= '0;
        end else if (flush) begin
            occ     <= '0;
            pend    <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            pend    <= fifo_rd_en;
            occ     <= occ_next;
            m_valid <= (occ_next != 2'd0);
            // Pop shifts skid forward; an arriving word then lands in the first free slot.
            if (pop && occ == 2'd2) begin
                head <= skid;
            end
            if (pend) begin
                if (occ_popped == 2'd0) begin
                    head <= fifo_rd_data;
                end else begin
                    skid <= fifo_rd_data;
                end
            end
        end
    end

`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
            if (m_valid && !m_ready && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Directed and randomized bench for fifo_stream_adapter against a queue-based reference model.
// Stats outputs are checked when FIFO_STREAM_ADAPTER_STATS_EN is defined.
module tb_fifo_stream_adapter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rd_data = '0;
    logic       fifo_rd_en;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
    logic       flush = 1'b0;
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    logic [15:0] beat_cnt;
    logic [15:0] stall_cnt;
    logic [15:0] beat_m = '0;
    logic [15:0] stall_m = '0;
`endif

    fifo_stream_adapter #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_ready(m_ready),
        .flush(flush)
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        ,
        .beat_cnt(beat_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // FIFO contents, words delivered but not yet popped, and whether a read is in flight.
    logic [7:0] fq[$];
    logic [7:0] obuf[$];
    int         pend_m = 0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   samp_cyc = 0;
    int   first_rd_cyc = -1;
    int   pops = 0;
    bit   started = 0;
    logic obs_valid, obs_rd;
    logic [7:0] obs_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic r, input logic fl, input logic rdy);
        logic       exp_valid, exp_pop, exp_rd;
        logic [7:0] arrive;
        @(negedge clk);
        rst        = r;
        flush      = fl;
        m_ready    = rdy;
        fifo_empty = (fq.size() == 0);
        #1;
        exp_valid = (obuf.size() != 0);
        exp_pop   = exp_valid && rdy;
        exp_rd    = !r && !fl && !fifo_empty && ((obuf.size() + pend_m - int'(exp_pop)) < 2);
        obs_valid = m_valid;
        obs_data  = m_data;
        obs_rd    = fifo_rd_en;
        samp_cyc  = cyc;
        if (started) begin
            chk("m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
            if (exp_valid) chk("m_data", {24'd0, m_data}, {24'd0, obuf[0]});
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
            chk("beat_cnt", {16'd0, beat_cnt}, {16'd0, beat_m});
            chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, stall_m});
`endif
        end
        chk("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
        if (fifo_empty) chk("rd_while_empty", {31'd0, fifo_rd_en}, 32'd0);
        if (exp_rd && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (exp_pop) pops++;
        arrive = fifo_rd_data;
        @(posedge clk);
        #1;
        cyc++;
        if (r || fl) begin
            obuf.delete();
            pend_m = 0;
        end else begin
            if (exp_pop) void'(obuf.pop_front());
            if (pend_m != 0) begin
                chk("overflow", {31'd0, obuf.size() < 2}, 32'd1);
                obuf.push_back(arrive);
            end
            pend_m = int'(exp_rd);
        end
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        if (r || fl) begin
            beat_m  = '0;
            stall_m = '0;
        end else begin
            if (exp_pop) beat_m = beat_m + 16'd1;
            if (exp_valid && !rdy && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
        end
`endif
        if (exp_rd) fifo_rd_data = fq.pop_front();
        started = 1;
    endtask

    initial begin
        int         beat, vcount, n, pushed, rel_cyc;
        logic [7:0] nxt, head_word;

        // Reset with a non-empty FIFO
        for (int i = 1; i <= 16; i++) fq.push_back(8'(i));
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("reset_m_valid", {31'd0, obs_valid}, 32'd0);
        chk("reset_m_data", {24'd0, obs_data}, 32'd0);
        chk("reset_rd_en", {31'd0, obs_rd}, 32'd0);

        // Streaming at full rate
        first_rd_cyc = -1;
        rel_cyc = cyc;
        beat = 0;
        nxt = 8'h01;
        for (int i = 0; i < 22; i++) begin
            step(0, 0, 1);
            if (obs_valid) begin
                chk("stream_data", {24'd0, obs_data}, {24'd0, nxt});
                chk("stream_cycle", samp_cyc, first_rd_cyc + 2 + beat);
                nxt = nxt + 8'd1;
                beat++;
            end
        end
        chk("first_rd_after_reset", first_rd_cyc, rel_cyc);
        chk("stream_beats", beat, 16);

        // Backpressure
        for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
        n = 0;
        do begin
            step(0, 0, 0);
            n++;
        end while (!obs_valid && n < 10);
        chk("bp_first_visible", {31'd0, obs_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0);
            chk("bp_hold", {24'd0, obs_data}, 32'h01);
        end
        chk("bp_no_issue", {31'd0, obs_rd}, 32'd0);
        chk("bp_model_full", obuf.size(), 2);
        nxt = 8'h01;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1);
            if (obs_valid) begin
                chk("bp_order", {24'd0, obs_data}, {24'd0, nxt});
                nxt = nxt + 8'd1;
            end
        end
        chk("bp_all_delivered", {24'd0, nxt}, 32'h09);

        // Drain three words to empty
        fq.push_back(8'hA1);
        fq.push_back(8'hA2);
        fq.push_back(8'hA3);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1);
            if (obs_valid) vcount++;
        end
        chk("drain_valid_cycles", vcount, 3);

        // Random backpressure with 200 random words
        pops = 0;
        pushed = 0;
        n = 0;
        while (!(pushed == 200 && fq.size() == 0 && obuf.size() == 0 && pend_m == 0) && n < 5000) begin
            if (pushed < 200 && ($urandom % 2) == 0) begin
                fq.push_back(8'($urandom));
                pushed++;
            end
            step(0, 0, 1'($urandom % 2));
            n++;
        end
        chk("random_done_in_budget", {31'd0, n < 5000}, 32'd1);
        chk("random_pops", pops, 200);

        // Flush with one word buffered and one in flight
        for (int i = 0; i < 8; i++) fq.push_back(8'hB0 + 8'(i));
        n = 0;
        while (!(obuf.size() == 1 && pend_m == 1) && n < 20) begin
            step(0, 0, 0);
            n++;
        end
        chk("flush1_setup", {31'd0, n < 20}, 32'd1);
        head_word = fq[0];
        step(0, 1, 0);
        step(0, 0, 0);
        chk("flush1_m_valid", {31'd0, obs_valid}, 32'd0);
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        chk("flush1_beat_cnt", {16'd0, beat_cnt}, 32'd0);
`endif
        n = 0;
        do begin
            step(0, 0, 0);
            n++;
        end while (!obs_valid && n < 10);
        chk("flush1_next_word", {24'd0, obs_data}, {24'd0, head_word});

        // Flush with both slots full, then drain
        n = 0;
        while (obuf.size() != 2 && n < 20) begin
            step(0, 0, 0);
            n++;
        end
        chk("flush2_setup", {31'd0, n < 20}, 32'd1);
        head_word = fq[0];
        step(0, 1, 0);
        step(0, 0, 1);
        chk("flush2_m_valid", {31'd0, obs_valid}, 32'd0);
        n = 0;
        do begin
            step(0, 0, 1);
            n++;
        end while (!obs_valid && n < 10);
        chk("flush2_next_word", {24'd0, obs_data}, {24'd0, head_word});
        for (int i = 0; i < 12; i++) step(0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
